// File: rtl/hilo_ctrl.sv
// hilo_ctrl
// ---------------------------------------------------------------------------
// Sequencer and HI/LO architectural state in front of a serial multiplier /
// divider (multdiv). Mult/div requests from decode are latched into operand
// registers and launched with a one-cycle md_start pulse; the result pair is
// captured into HI/LO when multdiv drops md_run. MTHI/MTLO write HI/LO
// directly and MFHI/MFLO read them combinationally, but only while idle.
//
// Handshake: op_valid/op/rs_data/rt_data are presented by decode. An op is
// accepted in any cycle where op_valid = 1 and stall = 0. When stall = 1 the
// op is not accepted and decode must hold it unchanged. For MFHI/MFLO the
// cycle of acceptance is also the cycle result_valid = 1.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   op_valid, op             request strobe and opcode
//   rs_data, rt_data         operands
//   stall                    request not accepted this cycle
//   result, result_valid     MFHI/MFLO read data and its qualifier
//   hi, lo                   architectural HI/LO registers
//   busy                     an operation is in flight (START or BUSY)
//   md_start                 one-cycle launch pulse to multdiv
//   md_multdivb, md_signedop operation select to multdiv
//   md_x, md_y               operand registers to multdiv
//   md_prodh, md_prodl       multdiv results (divide: remainder, quotient)
//   md_run                   multdiv busy
//   state_dbg                current FSM state (0 IDLE, 1 START, 2 BUSY)
// ---------------------------------------------------------------------------
module hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             md_start,
    output logic             md_multdivb,
    output logic             md_signedop,
    output logic [WIDTH-1:0] md_x,
    output logic [WIDTH-1:0] md_y,
    input  logic [WIDTH-1:0] md_prodh,
    input  logic [WIDTH-1:0] md_prodl,
    input  logic             md_run,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t state;

    logic idle;
    logic is_md;  // MULT, MULTU, DIV, DIVU
    logic is_mt;  // MTHI, MTLO
    logic is_mf;  // MFHI, MFLO

    assign idle  = (state == S_IDLE);
    assign is_md = ~op[2];
    assign is_mt = op[2] & ~op[1];
    assign is_mf = op[2] & op[1];

    // stall is a function of state and op_valid only, so md_run never
    // reaches decode combinationally. The MF op stalled in the completion
    // cycle is accepted one cycle later and reads the freshly captured pair.
    always_comb begin
        stall        = op_valid & ~idle;
        result_valid = op_valid & idle & is_mf;
        result       = '0;
        if (result_valid) begin
            result = op[0] ? lo : hi;
        end
        busy      = ~idle;
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            hi          <= '0;
            lo          <= '0;
            md_start    <= 1'b0;
            md_multdivb <= 1'b0;
            md_signedop <= 1'b0;
            md_x        <= '0;
            md_y        <= '0;
        end else begin
            md_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        if (is_md) begin
                            // Operand registers stay put until the next
                            // accepted mult/div, so multdiv may sample late.
                            md_x        <= rs_data;
                            md_y        <= rt_data;
                            md_multdivb <= ~op[1];
                            md_signedop <= ~op[0];
                            md_start    <= 1'b1;
                            state       <= S_START;
                        end else if (is_mt) begin
                            if (op[0]) begin
                                lo <= rs_data;
                            end else begin
                                hi <= rs_data;
                            end
                        end
                    end
                end
                S_START: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // multdiv raises md_run by the first BUSY cycle, so the
                    // first low md_run seen here marks completion.
                    if (!md_run) begin
                        hi    <= md_prodh;
                        lo    <= md_prodl;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs_data = '0, rt_data = '0;
  logic         stall, result_valid, busy;
  logic [W-1:0] result, hi, lo;
  logic         md_start, md_multdivb, md_signedop;
  logic [W-1:0] md_x, md_y;
  logic [W-1:0] md_prodh = '0, md_prodl = '0;
  logic         md_run = 1'b0;
  logic [1:0]   state_dbg;

  hilo_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .result(result), .result_valid(result_valid), .hi(hi), .lo(lo),
    .busy(busy), .md_start(md_start), .md_multdivb(md_multdivb),
    .md_signedop(md_signedop), .md_x(md_x), .md_y(md_y),
    .md_prodh(md_prodh), .md_prodl(md_prodl), .md_run(md_run),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0]     exp_q[$];     // expected MF read data, in program order
  logic [2*W+1:0]   launch_q[$];  // expected {multdivb, signedop, x, y}
  logic [W-1:0]     m_hi = '0, m_lo = '0;
  int n_launch = 0;
  int n_pulse  = 0;
  int md_lat   = 3;
  int cnt      = 0;
  bit prev_start = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- multdiv stand-in ----------------
  // Divide by zero returns remainder = dividend, quotient = all ones.
  function automatic logic [2*W-1:0] stub_calc(input logic mdb, input logic sg,
                                               input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    if (mdb) begin
      if (sg) p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
      else    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end else if (y == '0) begin
      p = {x, {W{1'b1}}};
    end else if (sg) begin
      p[2*W-1:W] = $signed(x) % $signed(y);
      p[W-1:0]   = $signed(x) / $signed(y);
    end else begin
      p = {x % y, x / y};
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      md_run <= 1'b0;
      cnt    <= 0;
    end else if (md_start) begin
      md_run <= 1'b1;
      cnt    <= md_lat;
      {md_prodh, md_prodl} <= stub_calc(md_multdivb, md_signedop, md_x, md_y);
    end else if (md_run) begin
      if (cnt <= 1) md_run <= 1'b0;
      cnt <= cnt - 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mf_unexpected: got result %h with no MF op expected", result);
        end else begin
          check("mf_result", result, exp_q.pop_front());
        end
      end else begin
        check("result_zero_when_invalid", result, '0);
      end
      if (md_start) begin
        n_pulse++;
        if (prev_start) begin
          tests++; fails++;
          $display("FAIL md_start_consecutive: got 2 high cycles expected 1");
        end
        if (launch_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL launch_unexpected: got md_start with none expected");
        end else begin
          logic [2*W+1:0] l;
          l = launch_q.pop_front();
          check("launch_multdivb", md_multdivb, l[2*W+1]);
          check("launch_signedop", md_signedop, l[2*W]);
          check("launch_x", md_x, l[2*W-1:W]);
          check("launch_y", md_y, l[W-1:0]);
        end
      end
    end
    prev_start = md_start;
  end

  // ---------------- reference model ----------------
  task automatic model_md(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    int unsigned ua, ub;
    longint sp;
    longint unsigned up;
    sa = a; sb = b; ua = a; ub = b;
    case (o)
      3'd0: begin sp = longint'(sa) * longint'(sb); m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd1: begin up = longint'(ua) * longint'(ub); m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd2: if (b == 0) begin m_hi = a; m_lo = '1; end
            else begin m_hi = sa % sb; m_lo = sa / sb; end
      default: if (b == 0) begin m_hi = a; m_lo = '1; end
               else begin m_hi = ua % ub; m_lo = ua / ub; end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int stalls);
    stalls = 0;
    if (o[2:1] == 2'b11) exp_q.push_back(o[0] ? m_lo : m_hi);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got stall after %0d cycles expected accept", stalls);
    end
    case (o)
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      3'd6, 3'd7: ;
      default: begin
        model_md(o, a, b);
        launch_q.push_back({~o[1], ~o[0], a, b});
        n_launch++;
      end
    endcase
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while (busy && c < 200) begin c++; @(negedge clk); end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic [2:0] o;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_md_start", md_start, 0);
    check("rst_md_x", md_x, '0);
    check("rst_md_y", md_y, '0);
    check("rst_md_multdivb", md_multdivb, 0);
    check("rst_md_signedop", md_signedop, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_state", state_dbg, 0);

    // MFLO right after reset
    do_op(3'd7, '0, '0, s);
    check("mflo_reset_stalls", s, 0);

    // MULT -1 x 2 with MFLO the next cycle
    md_lat = 3;
    do_op(3'd0, 32'hFFFFFFFF, 32'h2, s);
    do_op(3'd7, '0, '0, s);
    check("mflo_stall_cycles", s, md_lat + 2);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    // divides
    md_lat = 2;
    do_op(3'd3, 32'd7, 32'd2, s);
    wait_idle();
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd3);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, s);
    wait_idle();
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);

    // MTHI then MFHI
    do_op(3'd4, 32'h12345678, '0, s);
    check("mthi_stalls", s, 0);
    do_op(3'd6, '0, '0, s);
    check("mfhi_stalls", s, 0);
    check("mthi_lo_unchanged", lo, 32'hFFFFFFFD);

    // MULTU issued while busy
    md_lat = 4;
    do_op(3'd0, 32'd3, 32'd5, s);
    do_op(3'd1, 32'h80000000, 32'd4, s);
    check("multu_stall_cycles", s, md_lat + 2);
    wait_idle();
    check("multu_hi", hi, 32'd2);
    check("multu_lo", lo, 32'd0);
    check("pulse_count_b2b", n_pulse, n_launch);

    // reset two cycles into BUSY
    md_lat = 10;
    do_op(3'd0, 32'd3, 32'd5, s);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", state_dbg, 0);
    check("rst_mid_hi", hi, '0);
    check("rst_mid_lo", lo, '0);
    idle_cycles(15);
    check("rst_no_capture_hi", hi, '0);
    check("rst_no_capture_lo", lo, '0);

    // randomized program
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (!o[2] && o[1] && $urandom_range(0, 9) == 0) b = '0;
      if (o == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      md_lat = $urandom_range(1, 6);
      do_op(o, a, b, s);
      idle_cycles($urandom_range(0, 2));
    end
    wait_idle();
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);
    check("exp_q_drained", exp_q.size(), 0);
    check("launch_q_drained", launch_q.size(), 0);
    check("pulse_count", n_pulse, n_launch);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
